rst_seq: RTL
============

# rst_seq

Reset sequencer that produces the synchronous active-low resets consumed by the team's sync-reset flops. It accepts the board-level asynchronous reset, synchronizes its deassertion, holds reset for a programmable time, then releases N_OUT downstream reset outputs in a fixed order with a programmable gap between them. A software reset request re-runs the hold/release sequence without touching the asynchronous input. The block sits at the top of each clock domain, between the pad reset and all datapath logic.

## Interface
- SYNC_STAGES, 2: synchronizer depth for `i_rstn` deassertion; must be ≥ 2.
- N_OUT, 4: number of sequenced reset outputs; must be ≥ 1.
- HOLD_CYCLES, 16: cycles reset is held after synchronized deassertion; must be ≥ 1.
- STEP_CYCLES, 4: cycles between successive output releases; must be ≥ 1.

- `clk` in 1: single clock for all state.
- `i_rstn` in 1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronized internally.
- `i_sw_rst_req` in 1: software reset request, level-sampled on `clk`.
- `o_rstn` out N_OUT: sequenced active-low resets. Bit 0 releases first.
- `o_busy` out 1: high while in HOLD or RELEASE.
- `o_done` out 1: high only in RUN, when all outputs are released.
- `o_sw_rst_ack` out 1: one-cycle pulse when a software-initiated sequence completes.

## Operation
- **Asynchronous reset** (`i_rstn` = 0), immediately and independent of `clk`:
  - Synchronizer chain = 0, FSM = RESET, counters = 0.
  - `o_rstn` = all 0; `o_busy` = 0; `o_done` = 0; `o_sw_rst_ack` = 0.
- **Synchronizer:** SYNC_STAGES flops, all asynchronously cleared, shifting in 1. Its output `rst_ok` feeds the FSM.
- **FSM states:**
  - RESET → HOLD on the first edge that sees `rst_ok` = 1. The hold counter is cleared.
  - HOLD: the counter increments each cycle. After HOLD_CYCLES cycles in HOLD, go to RELEASE, set `o_rstn[0]` = 1, and clear the step counter.
  - RELEASE: every STEP_CYCLES cycles, release the next `o_rstn` bit (bits go to 1 in ascending index).
    - The edge that releases bit N_OUT-1 also enters RUN.
    - If N_OUT = 1, HOLD goes directly to RUN.
  - RUN: `o_done` = 1. If `i_sw_rst_req` = 1 is sampled, then on that edge:
    - `o_rstn` = all 0, `o_done` = 0, FSM → HOLD, hold counter cleared, `sw_pending` flag set.
- **Software request handling:**
  - `i_sw_rst_req` is ignored in RESET, HOLD and RELEASE. Requests are not queued.
  - A request held high across RUN entry starts a new sequence on the first RUN cycle.
- **Acknowledge:** on the edge entering RUN with `sw_pending` = 1, pulse `o_sw_rst_ack` for one cycle and clear `sw_pending`. A sequence started by power-on does not produce an ack.
- **Output ordering:** `o_rstn` bits never deassert out of order. Once high, a bit returns low only via async reset or a software request.
- **Counter width:** $clog2(max(HOLD_CYCLES, STEP_CYCLES)+1). Counters saturate and never wrap.
- **Mid-sequence async reset:** `i_rstn` going low at any point restarts from RESET. No partial state is kept.

## Timing
- Edge k is the k-th rising `clk` edge after `i_rstn` rises, with setup met.
- Power-on release schedule, with B = SYNC_STAGES + 1 + HOLD_CYCLES:
  - `o_rstn[i]` rises at edge B + i·STEP_CYCLES.
  - `o_done` rises at edge B + (N_OUT−1)·STEP_CYCLES.
  - `o_busy` is high from edge SYNC_STAGES+1 until `o_done` rises.
  - With defaults: bits rise at edges 19, 23, 27, 31; `o_done` at 31.
- Software sequence, with the request sampled at edge e:
  - All `o_rstn` go low at e.
  - `o_rstn[i]` rises at e + HOLD_CYCLES + i·STEP_CYCLES.
  - `o_sw_rst_ack` pulses high during the cycle after edge e + HOLD_CYCLES + (N_OUT−1)·STEP_CYCLES.
- All outputs are registered; there is no combinational path from inputs to outputs except the async clear.

## Structure
- Package `rst_seq_pkg` holds:
  - The state encoding localparams or typedef: RESET, HOLD, RELEASE, RUN.
  - Parameter legality checks as elaboration-time assertions.
- Sub-module `rst_sync`: parameterized-depth async-assert, sync-deassert flop chain. Reusable by other domains.
- Top level `rst_seq` contains the FSM, counters, release shift register and `sw_pending`.

## Test plan
- **Power-on, defaults:** `i_rstn` 0→1 → `o_rstn` goes 0001 at edge 19, 0011 at 23, 0111 at 27, 1111 at 31; `o_done` = 1 at 31; `o_sw_rst_ack` stays 0.
- **Async reset mid-RELEASE:** pulse `i_rstn` low between edges 24 and 25 → `o_rstn` = 0000 immediately without a clock; after release, the schedule repeats from edge 1.
- **Software reset:** `i_sw_rst_req` = 1 for one cycle at edge 40 in RUN → `o_rstn` = 0000 at 40; 0001 at 56; 1111 at 68; `o_sw_rst_ack` is a single-cycle pulse after 68.
- **Request ignored:** `i_sw_rst_req` = 1 during HOLD → schedule unchanged and no ack. If the request is still high at RUN entry, a new sequence starts on that cycle.
- **Corner parameters:** N_OUT=1, HOLD_CYCLES=1, STEP_CYCLES=1, SYNC_STAGES=2 → `o_rstn` and `o_done` both rise at edge 4.
- **Asynchronous glitch:** `i_rstn` low pulse shorter than one clock period → outputs clear and the full sequence re-runs.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and parameter helpers.
// Imported by rst_sync and rst_seq.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves both the hold and the step phases, so it is sized for the larger.
    function automatic int cnt_width(input int hold_cycles, input int step_cycles);
        return $clog2(max2(hold_cycles, step_cycles) + 1);
    endfunction

    function automatic bit params_legal(input int sync_stages, input int n_out,
                                        input int hold_cycles, input int step_cycles);
        return (sync_stages >= 2) && (n_out >= 1) && (hold_cycles >= 1) && (step_cycles >= 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchronizer of configurable depth.
// Output rst_ok is 0 immediately on i_rstn low and goes to 1 STAGES edges after release.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic i_rstn,
    output logic rst_ok
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_ok = chain_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronizes the pad reset, holds, then releases o_rstn bits in
// ascending order. A software request in RUN re-runs hold/release and is acknowledged.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N_OUT       = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             i_rstn,
    input  logic             i_sw_rst_req,
    output logic [N_OUT-1:0] o_rstn,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_sw_rst_ack,
    output state_t           o_dbg_state
);

    if (!params_legal(SYNC_STAGES, N_OUT, HOLD_CYCLES, STEP_CYCLES)) begin : g_param_check
        $error("rst_seq: illegal parameters (SYNC_STAGES>=2, N_OUT>=1, HOLD/STEP_CYCLES>=1)");
    end

    localparam int             CW        = cnt_width(HOLD_CYCLES, STEP_CYCLES);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  STEP_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX   = '1;
    localparam logic [N_OUT-1:0] FIRST   = N_OUT'(1);
    localparam logic [N_OUT-1:0] ALL_ONE = '1;

    logic rst_ok;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk    (clk),
        .i_rstn (i_rstn),
        .rst_ok (rst_ok)
    );

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_OUT-1:0] rstn_q, rstn_d;
    logic [N_OUT-1:0] shifted;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;
    logic             sw_pending_q, sw_pending_d;
    logic             enter_run;

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            rstn_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ack_q        <= 1'b0;
            sw_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rstn_q       <= rstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ack_q        <= ack_d;
            sw_pending_q <= sw_pending_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        rstn_d       = rstn_q;
        sw_pending_d = sw_pending_q;
        ack_d        = 1'b0;
        enter_run    = 1'b0;
        // Next release pattern: one more bit high, always filling from bit 0 upward.
        shifted      = (rstn_q << 1) | FIRST;

        case (state_q)
            ST_RESET: begin
                cnt_d = '0;
                if (rst_ok) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d  = '0;
                    rstn_d = FIRST;
                    if (N_OUT == 1) begin
                        state_d   = ST_RUN;
                        enter_run = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d  = '0;
                    rstn_d = shifted;
                    if (shifted == ALL_ONE) begin
                        state_d   = ST_RUN;
                        enter_run = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                // Requests only count here; anything seen in earlier states is dropped.
                if (i_sw_rst_req) begin
                    state_d      = ST_HOLD;
                    cnt_d        = '0;
                    rstn_d       = '0;
                    sw_pending_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
                rstn_d  = '0;
            end
        endcase

        if (enter_run && sw_pending_q) begin
            ack_d        = 1'b1;
            sw_pending_d = 1'b0;
        end

        busy_d = (state_d == ST_HOLD) || (state_d == ST_RELEASE);
        done_d = (state_d == ST_RUN);
    end

    assign o_rstn       = rstn_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_sw_rst_ack = ack_q;
    assign o_dbg_state  = state_q;

endmodule
